// File: rtl/sar_result_capture_if.sv
// Bus between the SAR sequencer/consumer and the result capture block.
interface sar_result_capture_if #(
    parameter int unsigned CNT_W = 8
);
    logic             VCOMP;
    logic             SAR_RESET;
    logic [2:0]       OUTEN;
    logic             RD_READY;
    logic [3:0]       DOUT;
    logic             DOUT_VALID;
    logic             OVERFLOW;
    logic             SEQ_ERR;
    logic [CNT_W-1:0] CONV_CNT;

    // Sequencer/consumer side.
    modport master (
        output VCOMP, SAR_RESET, OUTEN, RD_READY,
        input  DOUT, DOUT_VALID, OVERFLOW, SEQ_ERR, CONV_CNT
    );

    // Capture block side.
    modport slave (
        input  VCOMP, SAR_RESET, OUTEN, RD_READY,
        output DOUT, DOUT_VALID, OVERFLOW, SEQ_ERR, CONV_CNT
    );
endinterface

// File: rtl/sar_result_capture.sv
// Captures 4-bit SAR conversion results bit by bit from the sequencer phase
// strobes and queues completed words in a 2-entry FIFO for a downstream reader.
module sar_result_capture #(
    parameter int unsigned CNT_W = 8
) (
    input logic                 CLK,
    input logic                 RESET,
    sar_result_capture_if.slave bus
);

    typedef enum logic [2:0] {StIdle, StArmed, StB2, StB1, StB0} state_e;

    state_e           state_q, state_d;
    logic [2:0]       bits_q, bits_d;      // D3, D2, D1
    logic             seq_err_q, seq_err_d;
    logic [3:0]       head_q, head_d;
    logic [3:0]       tail_q, tail_d;
    logic             valid_q, valid_d;
    logic             full_q, full_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic       ev_multi, ev_illegal, ev_sar, ev_b3, ev_b2, ev_b1;
    logic       wrong;
    logic       push_req, pop;
    logic [3:0] push_word;

    assign ev_multi   = (bus.OUTEN & (bus.OUTEN - 3'd1)) != 3'd0;
    assign ev_illegal = ev_multi || (bus.SAR_RESET && bus.OUTEN != 3'd0);
    assign ev_sar     = bus.SAR_RESET && bus.OUTEN == 3'd0;
    assign ev_b3      = !bus.SAR_RESET && bus.OUTEN == 3'b100;
    assign ev_b2      = !bus.SAR_RESET && bus.OUTEN == 3'b010;
    assign ev_b1      = !bus.SAR_RESET && bus.OUTEN == 3'b001;
    assign push_word  = {bits_q, bus.VCOMP};

    // Capture FSM next state, partial-bit latching and sequence error detection.
    always_comb begin
        state_d   = state_q;
        bits_d    = bits_q;
        seq_err_d = 1'b0;
        push_req  = 1'b0;
        wrong     = 1'b0;
        if (ev_illegal) begin
            seq_err_d = 1'b1;
            bits_d    = 3'b000;
            state_d   = StIdle;
        end else if (ev_sar || ev_b3 || ev_b2 || ev_b1) begin
            unique case (state_q)
                StIdle: begin
                    // Bit strobes before arming are ignored silently.
                    if (ev_sar) state_d = StArmed;
                end
                StArmed: begin
                    if (ev_b3) begin
                        bits_d[2] = bus.VCOMP;
                        state_d   = StB2;
                    end else if (!ev_sar) begin
                        wrong = 1'b1;
                    end
                end
                StB2: begin
                    if (ev_b2) begin
                        bits_d[1] = bus.VCOMP;
                        state_d   = StB1;
                    end else begin
                        wrong = 1'b1;
                    end
                end
                StB1: begin
                    if (ev_b1) begin
                        bits_d[0] = bus.VCOMP;
                        state_d   = StB0;
                    end else begin
                        wrong = 1'b1;
                    end
                end
                StB0: begin
                    if (ev_sar) begin
                        push_req = 1'b1;
                        bits_d   = 3'b000;
                        state_d  = StArmed;
                    end else begin
                        wrong = 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
            if (wrong) begin
                seq_err_d = 1'b1;
                bits_d    = 3'b000;
                state_d   = ev_sar ? StArmed : StIdle;
            end
        end
    end

    assign pop = valid_q && bus.RD_READY;

    // FIFO next state: head/tail entries, occupancy flags, overflow and push count.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        valid_d = valid_q;
        full_d  = full_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        if (pop) begin
            if (full_q) begin
                head_d = tail_q;
                full_d = 1'b0;
            end else begin
                valid_d = 1'b0;
            end
        end
        if (push_req) begin
            if (!valid_q || (pop && !full_q)) begin
                // Empty, or the single entry leaves this cycle: word becomes the head.
                head_d  = push_word;
                valid_d = 1'b1;
                cnt_d   = cnt_q + CNT_W'(1);
            end else if (!full_q || pop) begin
                tail_d = push_word;
                full_d = 1'b1;
                cnt_d  = cnt_q + CNT_W'(1);
            end else begin
                ovf_d = 1'b1;
            end
        end
    end

    // State registers; synchronous reset wins over any push or pop.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= StIdle;
            bits_q    <= 3'b000;
            seq_err_q <= 1'b0;
            head_q    <= 4'b0000;
            tail_q    <= 4'b0000;
            valid_q   <= 1'b0;
            full_q    <= 1'b0;
            ovf_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            bits_q    <= bits_d;
            seq_err_q <= seq_err_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            valid_q   <= valid_d;
            full_q    <= full_d;
            ovf_q     <= ovf_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.DOUT       = head_q;
    assign bus.DOUT_VALID = valid_q;
    assign bus.OVERFLOW   = ovf_q;
    assign bus.SEQ_ERR    = seq_err_q;
    assign bus.CONV_CNT   = cnt_q;

endmodule

// File: tb/tb_sar_result_capture.sv
// Self-checking bench for sar_result_capture: hand-derived vector table,
// directed queue/reset sequences, and random stimulus against a queue model.
module tb_sar_result_capture;

    localparam int unsigned CNT_W = 2;

    logic CLK = 1'b0;
    logic RESET = 1'b1;

    sar_result_capture_if #(.CNT_W(CNT_W)) bus();

    sar_result_capture #(.CNT_W(CNT_W)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state.
    bit         m_armed;
    bit         m_bits[$];
    logic [3:0] m_q[$];
    bit         m_ovf;
    bit         m_err;
    int         m_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_step(input logic rst, input logic sar, input logic [2:0] oe,
                              input logic vc, input logic rd);
        bit         pop;
        bit         push;
        logic [3:0] word;
        logic [2:0] want;
        int         ones;
        if (rst) begin
            m_armed = 0; m_bits.delete(); m_q.delete();
            m_ovf = 0; m_err = 0; m_cnt = 0;
            return;
        end
        pop  = (m_q.size() != 0) && rd;
        push = 0;
        word = 4'b0000;
        ones = $countones(oe);
        m_err = 0;
        if (ones > 1 || (sar && ones != 0)) begin
            m_err = 1; m_armed = 0; m_bits.delete();
        end else if (sar) begin
            if (!m_armed) begin
                m_armed = 1;
            end else if (m_bits.size() == 3) begin
                push = 1;
                word = {m_bits[0], m_bits[1], m_bits[2], vc};
                m_bits.delete();
            end else if (m_bits.size() != 0) begin
                m_err = 1; m_bits.delete();
            end
        end else if (ones == 1 && m_armed) begin
            want = 3'b100;
            want = want >> m_bits.size();
            if (m_bits.size() < 3 && oe == want) begin
                m_bits.push_back(vc);
            end else begin
                m_err = 1; m_armed = 0; m_bits.delete();
            end
        end
        if (pop) void'(m_q.pop_front());
        if (push) begin
            if (m_q.size() < 2) begin
                m_q.push_back(word);
                m_cnt = (m_cnt + 1) % (1 << CNT_W);
            end else begin
                m_ovf = 1;
            end
        end
    endtask

    // Apply one cycle of inputs, clock, update the model and compare against it.
    task automatic cycle(input logic rst, input logic sar, input logic [2:0] oe,
                         input logic vc, input logic rd);
        RESET = rst; bus.SAR_RESET = sar; bus.OUTEN = oe; bus.VCOMP = vc; bus.RD_READY = rd;
        @(posedge CLK);
        model_step(rst, sar, oe, vc, rd);
        #1;
        check("model valid", 32'(bus.DOUT_VALID), 32'(m_q.size() != 0));
        if (m_q.size() != 0) check("model dout", 32'(bus.DOUT), 32'(m_q[0]));
        check("model overflow", 32'(bus.OVERFLOW), 32'(m_ovf));
        check("model seq_err", 32'(bus.SEQ_ERR), 32'(m_err));
        check("model conv_cnt", 32'(bus.CONV_CNT), 32'(m_cnt));
    endtask

    task automatic conv(input logic [3:0] w, input logic rd_last);
        cycle(0, 1, 3'b000, 0, 0);
        cycle(0, 0, 3'b100, w[3], 0);
        cycle(0, 0, 3'b010, w[2], 0);
        cycle(0, 0, 3'b001, w[1], 0);
        cycle(0, 1, 3'b000, w[0], rd_last);
    endtask

    typedef struct {
        logic       rst;
        logic       sar;
        logic [2:0] oe;
        logic       vc;
        logic       rd;
        logic [3:0] e_dout;
        logic       e_val;
        logic       e_ovf;
        logic       e_err;
        logic [1:0] e_cnt;
    } vec_t;

    vec_t vecs[$];

    initial begin
        bus.SAR_RESET = 0; bus.OUTEN = 3'b000; bus.VCOMP = 0; bus.RD_READY = 0;

        //                rst sar oe      vc rd  dout     val ovf err cnt
        vecs.push_back('{1, 0, 3'b000, 0, 0, 4'b0000, 0, 0, 0, 2'd0}); // reset state
        vecs.push_back('{0, 1, 3'b000, 0, 0, 4'b0000, 0, 0, 0, 2'd0}); // arm
        vecs.push_back('{0, 0, 3'b000, 0, 0, 4'b0000, 0, 0, 0, 2'd0}); // idle
        vecs.push_back('{0, 0, 3'b100, 1, 0, 4'b0000, 0, 0, 0, 2'd0});
        vecs.push_back('{0, 0, 3'b010, 0, 0, 4'b0000, 0, 0, 0, 2'd0});
        vecs.push_back('{0, 0, 3'b001, 1, 0, 4'b0000, 0, 0, 0, 2'd0});
        vecs.push_back('{0, 1, 3'b000, 1, 0, 4'b1011, 1, 0, 0, 2'd1}); // push 1011
        vecs.push_back('{0, 0, 3'b000, 0, 1, 4'b0000, 0, 0, 0, 2'd1}); // pop
        vecs.push_back('{0, 0, 3'b010, 0, 0, 4'b0000, 0, 0, 1, 2'd1}); // 010 while armed
        vecs.push_back('{0, 0, 3'b000, 0, 0, 4'b0000, 0, 0, 0, 2'd1});
        vecs.push_back('{0, 0, 3'b100, 1, 0, 4'b0000, 0, 0, 0, 2'd1}); // strobe in idle: no error
        vecs.push_back('{0, 1, 3'b000, 0, 0, 4'b0000, 0, 0, 0, 2'd1});
        vecs.push_back('{0, 0, 3'b110, 0, 0, 4'b0000, 0, 0, 1, 2'd1}); // multi-hot
        vecs.push_back('{0, 1, 3'b000, 0, 0, 4'b0000, 0, 0, 0, 2'd1});
        vecs.push_back('{0, 0, 3'b100, 0, 0, 4'b0000, 0, 0, 0, 2'd1});
        vecs.push_back('{0, 0, 3'b010, 1, 0, 4'b0000, 0, 0, 0, 2'd1});
        vecs.push_back('{0, 1, 3'b000, 0, 0, 4'b0000, 0, 0, 1, 2'd1}); // SAR_RESET in B1
        vecs.push_back('{0, 0, 3'b100, 1, 0, 4'b0000, 0, 0, 0, 2'd1});
        vecs.push_back('{0, 0, 3'b010, 1, 0, 4'b0000, 0, 0, 0, 2'd1});
        vecs.push_back('{0, 0, 3'b001, 0, 0, 4'b0000, 0, 0, 0, 2'd1});
        vecs.push_back('{0, 1, 3'b000, 0, 0, 4'b1100, 1, 0, 0, 2'd2}); // push 1100
        vecs.push_back('{0, 0, 3'b000, 0, 1, 4'b0000, 0, 0, 0, 2'd2});
        vecs.push_back('{0, 1, 3'b001, 0, 0, 4'b0000, 0, 0, 1, 2'd2}); // SAR_RESET + OUTEN
        vecs.push_back('{0, 0, 3'b000, 0, 0, 4'b0000, 0, 0, 0, 2'd2});

        @(negedge CLK);
        foreach (vecs[i]) begin
            cycle(vecs[i].rst, vecs[i].sar, vecs[i].oe, vecs[i].vc, vecs[i].rd);
            check($sformatf("vec%0d valid", i), 32'(bus.DOUT_VALID), 32'(vecs[i].e_val));
            if (vecs[i].e_val || vecs[i].rst)
                check($sformatf("vec%0d dout", i), 32'(bus.DOUT), 32'(vecs[i].e_dout));
            check($sformatf("vec%0d overflow", i), 32'(bus.OVERFLOW), 32'(vecs[i].e_ovf));
            check($sformatf("vec%0d seq_err", i), 32'(bus.SEQ_ERR), 32'(vecs[i].e_err));
            check($sformatf("vec%0d conv_cnt", i), 32'(bus.CONV_CNT), 32'(vecs[i].e_cnt));
        end

        // Backpressure: third word dropped.
        cycle(1, 0, 3'b000, 0, 0);
        conv(4'b1011, 0); conv(4'b0110, 0); conv(4'b1111, 0);
        check("bp head", 32'(bus.DOUT), 32'h0b);
        check("bp overflow", 32'(bus.OVERFLOW), 32'd1);
        check("bp conv_cnt", 32'(bus.CONV_CNT), 32'd2);
        cycle(0, 0, 3'b000, 0, 0);
        check("bp hold dout", 32'(bus.DOUT), 32'h0b);
        cycle(0, 0, 3'b000, 0, 1);
        check("bp second", 32'(bus.DOUT), 32'h06);
        check("bp second valid", 32'(bus.DOUT_VALID), 32'd1);
        cycle(0, 0, 3'b000, 0, 1);
        check("bp drained", 32'(bus.DOUT_VALID), 32'd0);
        check("bp overflow sticky", 32'(bus.OVERFLOW), 32'd1);

        // Full queue, third push with a coincident pop.
        cycle(1, 0, 3'b000, 0, 0);
        conv(4'b1011, 0); conv(4'b0110, 0); conv(4'b1111, 1);
        check("fp overflow", 32'(bus.OVERFLOW), 32'd0);
        check("fp conv_cnt", 32'(bus.CONV_CNT), 32'd3);
        check("fp head", 32'(bus.DOUT), 32'h06);
        cycle(0, 0, 3'b000, 0, 1);
        check("fp third", 32'(bus.DOUT), 32'h0f);
        cycle(0, 0, 3'b000, 0, 1);
        check("fp drained", 32'(bus.DOUT_VALID), 32'd0);

        // Reset while in B0 with one queued word, coincident with the B0 strobe.
        cycle(1, 0, 3'b000, 0, 0);
        conv(4'b1010, 0);
        cycle(0, 1, 3'b000, 0, 0);
        cycle(0, 0, 3'b100, 1, 0);
        cycle(0, 0, 3'b010, 1, 0);
        cycle(0, 0, 3'b001, 1, 0);
        cycle(1, 1, 3'b000, 1, 1);
        check("rst dout", 32'(bus.DOUT), 32'd0);
        check("rst valid", 32'(bus.DOUT_VALID), 32'd0);
        check("rst seq_err", 32'(bus.SEQ_ERR), 32'd0);
        check("rst conv_cnt", 32'(bus.CONV_CNT), 32'd0);
        cycle(0, 1, 3'b000, 1, 0);
        check("rst arm no push", 32'(bus.DOUT_VALID), 32'd0);
        check("rst arm cnt", 32'(bus.CONV_CNT), 32'd0);

        // Counter wrap with CNT_W=2: 1,2,3,0,1.
        cycle(1, 0, 3'b000, 0, 0);
        for (int k = 0; k < 5; k++) begin
            conv(4'(k + 5), 0);
            check($sformatf("wrap cnt%0d", k), 32'(bus.CONV_CNT), 32'((k + 1) % 4));
            cycle(0, 0, 3'b000, 0, 1);
        end

        // Random stimulus, biased towards legal sequences.
        cycle(1, 0, 3'b000, 0, 0);
        for (int n = 0; n < 3000; n++) begin
            int         r;
            logic       sar;
            logic       rst;
            logic [2:0] oe;
            r   = int'($urandom_range(0, 15));
            rst = 0; sar = 0; oe = 3'b000;
            if (r >= 3 && r <= 4) begin
                sar = 1;
            end else if (r >= 5 && r <= 11) begin
                if (!m_armed || m_bits.size() == 3) sar = 1;
                else begin
                    oe = 3'b100;
                    oe = oe >> m_bits.size();
                end
            end else if (r == 12) begin
                oe = 3'b001 << $urandom_range(0, 2);
            end else if (r == 13) begin
                case ($urandom_range(0, 3))
                    0: oe = 3'b011;
                    1: oe = 3'b101;
                    2: oe = 3'b110;
                    default: oe = 3'b111;
                endcase
            end else if (r == 14) begin
                sar = 1;
                oe  = 3'b001 << $urandom_range(0, 2);
            end else if (r == 15) begin
                rst = ($urandom_range(0, 9) == 0);
            end
            cycle(rst, sar, oe, 1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sar_result_capture.md
SAR_RESULT_CAPTURE -- requirements
Module: sar_result_capture

Interface
REQ-001 Parameter: CNT_W, default 8, width of the conversion counter CONV_CNT.
REQ-002 CLK  input  1  sole clock; all state updates on the rising edge.
REQ-003 RESET  input  1  synchronous, active-high reset, sampled on the CLK rising edge.
REQ-004 VCOMP  input  1  comparator decision for the bit currently being resolved.
REQ-005 SAR_RESET  input  1  sample-phase strobe from the upstream SAR sequencer.
REQ-006 OUTEN  input  3  one-hot bit-phase enables from the upstream sequencer: 100=bit3, 010=bit2, 001=bit1.
REQ-007 RD_READY  input  1  consumer accepts DOUT this cycle.
REQ-008 DOUT  output  4  head-of-queue conversion result, MSB first.
REQ-009 DOUT_VALID  output  1  DOUT holds an unread result.
REQ-010 OVERFLOW  output  1  sticky flag: a completed result was dropped because the queue was full.
REQ-011 SEQ_ERR  output  1  one-cycle pulse on an illegal or out-of-order phase sequence.
REQ-012 CONV_CNT  output  CNT_W  count of results pushed into the queue.

Function
REQ-013 An "idle cycle" has OUTEN=000 and SAR_RESET=0; idle cycles shall not change the capture FSM, in any state.
REQ-014 Capture FSM states shall be IDLE, ARMED, B2, B1 and B0.
REQ-015 IDLE: SAR_RESET=1 -> ARMED; OUTEN events -> stay in IDLE, with no SEQ_ERR.
REQ-016 ARMED: OUTEN=100 -> latch D3=VCOMP, go to B2; SAR_RESET=1 -> stay in ARMED.
REQ-017 B2: OUTEN=010 -> latch D2=VCOMP, go to B1.
REQ-018 B1: OUTEN=001 -> latch D1=VCOMP, go to B0.
REQ-019 B0: SAR_RESET=1 -> D0=VCOMP, push word {D3,D2,D1,VCOMP}, go to ARMED.
REQ-020 In ARMED/B2/B1/B0, any legal event other than the expected one:
- SEQ_ERR pulses for one cycle;
- the partial word is discarded;
- next state is ARMED if the event was SAR_RESET=1, otherwise IDLE.
REQ-021 Illegal input codes shall, in any state including IDLE, pulse SEQ_ERR, discard the partial word and go to IDLE. Illegal codes are:
- OUTEN with more than one bit set;
- SAR_RESET=1 together with OUTEN≠000.
REQ-022 SEQ_ERR shall be registered: it is high in the cycle after the offending edge.
REQ-023 The queue shall be a 2-entry FIFO; DOUT and DOUT_VALID reflect the head entry directly from registers.
REQ-024 Push latency: a word pushed into an empty queue shall appear with DOUT_VALID=1 in the cycle after the B0 SAR_RESET edge.
REQ-025 Pop shall occur on an edge where DOUT_VALID=1 and RD_READY=1; RD_READY while empty has no effect.
REQ-026 Push while full and not popping: the new word is dropped, OVERFLOW is set, and OVERFLOW stays set until RESET.
REQ-027 Push while full with a simultaneous pop: both succeed, the queue stays full, and OVERFLOW is unchanged.
REQ-028 DOUT shall hold its value while DOUT_VALID=1 and RD_READY=0.
REQ-029 CONV_CNT shall increment by 1 only on a successful push (not on dropped words), wrapping from 2^CNT_W-1 to 0.

Reset
REQ-030 RESET=1 at a CLK edge shall force:
- FSM to IDLE;
- queue to empty;
- DOUT=0000, DOUT_VALID=0, OVERFLOW=0, SEQ_ERR=0, CONV_CNT=0;
- partial bits D3..D1 cleared.
REQ-031 RESET mid-conversion shall discard the partial word without SEQ_ERR.
REQ-032 After RESET, the first SAR_RESET only arms the FSM and shall not push.
REQ-033 RESET dominates a simultaneous push or pop.

Verification
REQ-034 Nominal conversion: SAR_RESET, idle, OUTEN=100 (VCOMP=1), 010 (0), 001 (1), then SAR_RESET (VCOMP=1) -> next cycle DOUT=1011, DOUT_VALID=1, CONV_CNT=1.
REQ-035 Backpressure: three conversions 1011, 0110, 1111 with RD_READY=0 -> queue holds 1011 then 0110; OVERFLOW=1; CONV_CNT=2. Then RD_READY=1 -> pops 1011, then 0110, then DOUT_VALID=0.
REQ-036 Full queue, third push coincident with RD_READY=1 -> no OVERFLOW; reads return the 2nd then 3rd word; CONV_CNT=3.
REQ-037 Out-of-order and illegal codes:
- OUTEN=010 while ARMED -> SEQ_ERR pulse, FSM in IDLE, no push.
- OUTEN=110 in any state -> SEQ_ERR pulse, FSM in IDLE.
- SAR_RESET while in B1 -> SEQ_ERR pulse, FSM in ARMED, next full sequence pushes correctly.
REQ-038 RESET asserted while in B0 with one queued word -> all outputs zero; a following SAR_RESET does not push.
REQ-039 With CNT_W=2, five successful conversions, each read out -> CONV_CNT sequence 1,2,3,0,1.
